// File: rtl/mgt_link_monitor_pkg.sv
// Shared definitions for the transceiver link monitor: lane FSM encoding and
// the field layout of the counter readout word.
package mgt_link_monitor_pkg;

    typedef enum logic [1:0] {
        LANE_DOWN = 2'd0,
        LANE_QUAL = 2'd1,
        LANE_UP   = 2'd2
    } lane_state_e;

    // Readout word is {dropCount, errCount}; field index times CNT_WIDTH gives the LSB.
    localparam int CSR_ERR_FIELD  = 0;
    localparam int CSR_DROP_FIELD = 1;
    localparam int CSR_FIELDS     = 2;

endpackage

// File: rtl/mgt_link_monitor_lane_qualifier.sv
// One monitored lane: link-up synchronizer, DOWN/QUAL/UP qualification FSM,
// and saturating drop/error counters with a synchronous clear.
module mgt_lane_qualifier
    import mgt_link_monitor_pkg::*;
#(
    parameter int CNT_WIDTH   = 16,
    parameter int QUAL_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 lane_up_async,
    input  logic                 err_strobe,
    input  logic                 clear,
    output logic                 stable,
    output logic [CNT_WIDTH-1:0] drop_count,
    output logic [CNT_WIDTH-1:0] err_count
);

    localparam int QW = (QUAL_CYCLES > 1) ? $clog2(QUAL_CYCLES) : 1;
    localparam logic [QW-1:0] QUAL_LAST = QW'(QUAL_CYCLES - 1);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                     input logic inc);
        if (!inc || (&v))
            return v;
        return v + 1'b1;
    endfunction

    logic          sync_meta;
    logic          lane_up_s;
    lane_state_e   state_q, state_d;
    logic [QW-1:0] qual_q, qual_d;
    logic          drop_evt;
    logic          err_evt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            lane_up_s <= 1'b0;
        end else begin
            sync_meta <= lane_up_async;
            lane_up_s <= sync_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LANE_DOWN;
            qual_q  <= '0;
            stable  <= 1'b0;
        end else begin
            state_q <= state_d;
            qual_q  <= qual_d;
            stable  <= (state_d == LANE_UP);
        end
    end

    always_comb begin
        state_d  = state_q;
        qual_d   = qual_q;
        drop_evt = 1'b0;
        case (state_q)
            LANE_DOWN: begin
                qual_d = '0;
                if (lane_up_s)
                    state_d = LANE_QUAL;
            end
            LANE_QUAL: begin
                if (!lane_up_s) begin
                    state_d = LANE_DOWN;
                    qual_d  = '0;
                end else if (qual_q == QUAL_LAST) begin
                    state_d = LANE_UP;
                    qual_d  = '0;
                end else begin
                    qual_d = qual_q + 1'b1;
                end
            end
            LANE_UP: begin
                if (!lane_up_s) begin
                    state_d  = LANE_DOWN;
                    drop_evt = 1'b1;
                end
            end
            default: state_d = LANE_DOWN;
        endcase
    end

    assign err_evt = err_strobe && (state_q == LANE_UP);

    // A clear that coincides with an event leaves the count at one, not zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
            err_count  <= '0;
        end else if (clear) begin
            drop_count <= CNT_WIDTH'(drop_evt);
            err_count  <= CNT_WIDTH'(err_evt);
        end else begin
            drop_count <= sat_inc(drop_count, drop_evt);
            err_count  <= sat_inc(err_count, err_evt);
        end
    end

endmodule

// File: rtl/mgt_link_monitor.sv
// Multi-lane transceiver link monitor: per-lane qualifiers plus the CSR
// readout mux, clear fan-out and aggregate status LED.
module mgt_link_monitor
    import mgt_link_monitor_pkg::*;
#(
    parameter int NLANES      = 8,
    parameter int CNT_WIDTH   = 16,
    parameter int QUAL_CYCLES = 1024,
    parameter int BLINK_LOG2  = 24
) (
    input  logic                            sysClk,
    input  logic                            sysReset_n,
    input  logic [NLANES-1:0]               laneUpAsync,
    input  logic [NLANES-1:0]               laneErrStrobe,
    input  logic [3:0]                      csrLaneSel,
    input  logic                            csrClear,
    input  logic [NLANES-1:0]               csrClearMask,
    output logic [CSR_FIELDS*CNT_WIDTH-1:0] csrData,
    output logic [NLANES-1:0]               laneStable,
    output logic                            statusLED
);

    logic [NLANES-1:0]               lane_clear;
    logic [CNT_WIDTH-1:0]            drop_cnt [NLANES];
    logic [CNT_WIDTH-1:0]            err_cnt  [NLANES];
    logic [CSR_FIELDS*CNT_WIDTH-1:0] csr_sel;
    logic [BLINK_LOG2:0]             blink_q;
    logic                            led_d;

    assign lane_clear = {NLANES{csrClear}} & csrClearMask;

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        mgt_lane_qualifier #(
            .CNT_WIDTH   (CNT_WIDTH),
            .QUAL_CYCLES (QUAL_CYCLES)
        ) u_lane (
            .clk           (sysClk),
            .rst_n         (sysReset_n),
            .lane_up_async (laneUpAsync[i]),
            .err_strobe    (laneErrStrobe[i]),
            .clear         (lane_clear[i]),
            .stable        (laneStable[i]),
            .drop_count    (drop_cnt[i]),
            .err_count     (err_cnt[i])
        );
    end

    // Unmatched selects (>= NLANES) fall through to the all-zero default.
    always_comb begin
        csr_sel = '0;
        for (int i = 0; i < NLANES; i++) begin
            if (csrLaneSel == 4'(i)) begin
                csr_sel[CSR_DROP_FIELD*CNT_WIDTH +: CNT_WIDTH] = drop_cnt[i];
                csr_sel[CSR_ERR_FIELD*CNT_WIDTH +: CNT_WIDTH]  = err_cnt[i];
            end
        end
    end

    always_comb begin
        led_d = 1'b0;
        if (&laneStable)
            led_d = 1'b1;
        else if (|laneStable)
            led_d = blink_q[BLINK_LOG2];
    end

    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            csrData   <= '0;
            statusLED <= 1'b0;
            blink_q   <= '0;
        end else begin
            csrData   <= csr_sel;
            statusLED <= led_d;
            blink_q   <= blink_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_mgt_link_monitor.sv
// Bench for mgt_link_monitor: directed scenarios plus randomized traffic,
// checked every cycle against a run-length based reference model.
module tb_mgt_link_monitor;

    localparam int NL = 8;
    localparam int CW = 4;
    localparam int QC = 16;
    localparam int BL = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NL-1:0]   up_in;
    logic [NL-1:0]   err_in;
    logic [3:0]      sel;
    logic            clr;
    logic [NL-1:0]   mask;
    logic [2*CW-1:0] csr;
    logic [NL-1:0]   stable;
    logic            led;

    int n_tests = 0;
    int n_fail  = 0;
    bit rand_sel = 0;

    // Reference model state
    int              run_m  [NL];
    bit              stb_m  [NL];
    int              drop_m [NL];
    int              err_m  [NL];
    bit              s1_m   [NL];
    bit              s2_m   [NL];
    logic [2*CW-1:0] csr_m;
    bit              led_m;
    int              div_m;

    mgt_link_monitor #(
        .NLANES      (NL),
        .CNT_WIDTH   (CW),
        .QUAL_CYCLES (QC),
        .BLINK_LOG2  (BL)
    ) dut (
        .sysClk        (clk),
        .sysReset_n    (rst_n),
        .laneUpAsync   (up_in),
        .laneErrStrobe (err_in),
        .csrLaneSel    (sel),
        .csrClear      (clr),
        .csrClearMask  (mask),
        .csrData       (csr),
        .laneStable    (stable),
        .statusLED     (led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            run_m[i] = 0; stb_m[i] = 0; drop_m[i] = 0; err_m[i] = 0;
            s1_m[i] = 0; s2_m[i] = 0;
        end
        csr_m = '0;
        led_m = 0;
        div_m = 0;
    endtask

    // A lane is up once its synchronized level has been high for QC+1
    // consecutive samples (one to enter qualification, QC to complete it).
    task automatic model_edge();
        logic [2*CW-1:0] n_csr;
        bit n_led;
        int n_up;
        bit ups, was_up, inc_d, inc_e;
        n_csr = '0;
        if (int'(sel) < NL) begin
            n_csr[2*CW-1:CW] = CW'(drop_m[int'(sel)]);
            n_csr[CW-1:0]    = CW'(err_m[int'(sel)]);
        end
        n_up = 0;
        for (int i = 0; i < NL; i++) n_up += stb_m[i];
        if (n_up == NL)     n_led = 1;
        else if (n_up == 0) n_led = 0;
        else                n_led = ((div_m >> BL) & 1) == 1;
        div_m = (div_m + 1) % (1 << (BL + 1));
        for (int i = 0; i < NL; i++) begin
            ups    = s2_m[i];
            was_up = stb_m[i];
            inc_d  = was_up && !ups;
            inc_e  = was_up && err_in[i];
            run_m[i] = ups ? ((run_m[i] < 1000) ? run_m[i] + 1 : 1000) : 0;
            stb_m[i] = (run_m[i] >= QC + 1);
            if (clr && mask[i]) begin
                drop_m[i] = inc_d ? 1 : 0;
                err_m[i]  = inc_e ? 1 : 0;
            end else begin
                drop_m[i] = (drop_m[i] + inc_d > CMAX) ? CMAX : drop_m[i] + inc_d;
                err_m[i]  = (err_m[i] + inc_e > CMAX) ? CMAX : err_m[i] + inc_e;
            end
            s2_m[i] = s1_m[i];
            s1_m[i] = up_in[i];
        end
        csr_m = n_csr;
        led_m = n_led;
    endtask

    task automatic check_all();
        logic [NL-1:0] exp_stb;
        for (int i = 0; i < NL; i++) exp_stb[i] = stb_m[i];
        check("laneStable", 32'(stable), 32'(exp_stb));
        check("statusLED", 32'(led), 32'(led_m));
        check("csrData", 32'(csr), 32'(csr_m));
    endtask

    task automatic step();
        if (rand_sel) sel = 4'($urandom_range(0, 15));
        model_edge();
        @(posedge clk);
        #1;
        err_in = '0;
        clr    = 1'b0;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        bit seen;
        int trans;
        logic prev;

        rst_n = 1'b0; up_in = '0; err_in = '0; sel = '0; clr = 1'b0; mask = '0;
        model_reset();
        #12;
        check("reset_laneStable", 32'(stable), 32'h0);
        check("reset_statusLED", 32'(led), 32'h0);
        check("reset_csrData", 32'(csr), 32'h0);
        rst_n = 1'b1;
        steps(3);

        // Short pulse on lane 2 never qualifies
        seen = 0;
        up_in[2] = 1'b1;
        for (int k = 0; k < 10; k++) begin step(); seen |= stable[2]; end
        up_in[2] = 1'b0;
        for (int k = 0; k < 25; k++) begin step(); seen |= stable[2]; end
        check("lane2_short_never_up", 32'(seen), 32'h0);
        sel = 4'd2;
        step();
        check("lane2_short_drop", 32'(csr[2*CW-1:CW]), 32'h0);

        // Qualification latency: 2 sync + 16 qual + 1 register
        up_in[2] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 18) check("lane2_not_yet_up", 32'(stable[2]), 32'h0);
            if (k == 19) check("lane2_up_at_19", 32'(stable[2]), 32'h1);
        end

        // Lane 0 drop counter saturation, with background error noise
        for (int t = 0; t < 20; t++) begin
            up_in[0] = 1'b1;
            for (int k = 0; k < 22; k++) begin
                err_in = NL'($urandom) & 8'hFD;
                step();
            end
            up_in[0] = 1'b0;
            steps(4);
        end
        sel = 4'd0;
        step();
        check("lane0_drop_saturated", 32'(csr[2*CW-1:CW]), 32'(CMAX));

        // Lane 1 error counting only while UP
        up_in[1] = 1'b1;
        steps(22);
        for (int k = 0; k < 3; k++) begin err_in[1] = 1'b1; step(); step(); end
        up_in[1] = 1'b0;
        steps(4);
        for (int k = 0; k < 2; k++) begin err_in[1] = 1'b1; step(); step(); end
        sel = 4'd1;
        step();
        check("lane1_err_3", 32'(csr[CW-1:0]), 32'h3);
        up_in[1] = 1'b1;
        steps(22);
        clr = 1'b1; mask = 8'h02; err_in[1] = 1'b1;
        step();
        step();
        check("lane1_clear_plus_strobe", 32'(csr), 32'h01);

        // Readout select out of range and latency
        sel = 4'd9;
        step();
        check("sel9_zero", 32'(csr), 32'h0);
        sel = 4'd1;
        step();
        check("sel1_lane1", 32'(csr), 32'h01);

        // Status LED: all up, some up (blinking), none up
        up_in = 8'hFF;
        steps(22);
        check("all_up_stable", 32'(stable), 32'hFF);
        check("all_up_led", 32'(led), 32'h1);
        up_in = 8'h0F;
        steps(6);
        check("half_up_stable", 32'(stable), 32'h0F);
        trans = 0;
        prev = led;
        for (int k = 0; k < 32; k++) begin
            step();
            if (led !== prev) trans++;
            prev = led;
        end
        check("half_up_led_toggles", 32'(trans), 32'd4);
        up_in = 8'h00;
        steps(5);
        check("none_up_led", 32'(led), 32'h0);

        // Randomized traffic
        rand_sel = 1;
        for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < NL; i++)
                if ($urandom_range(0, 39) == 0) up_in[i] = ~up_in[i];
            err_in = NL'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                clr  = 1'b1;
                mask = NL'($urandom);
            end
            step();
        end
        rand_sel = 0;

        // Asynchronous reset with lanes UP and others mid-qualification
        up_in = 8'h0F;
        steps(22);
        err_in = 8'h0F;
        step();
        up_in = 8'hFF;
        steps(10);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_laneStable", 32'(stable), 32'h0);
        check("async_rst_statusLED", 32'(led), 32'h0);
        check("async_rst_csrData", 32'(csr), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        for (int i = 0; i < NL; i++) begin
            sel = 4'(i);
            step();
            check("post_rst_counters", 32'(csr), 32'h0);
        end
        steps(12);
        check("requalified_all", 32'(stable), 32'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
